// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: state encoding, the default
// program-counter width and the program-index wrap helper.
package seq_pkg;

    localparam int unsigned SEQ_PC_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOAD,
        RUN,
        DONE
    } seq_state_t;

    // Advance to the next program slot, wrapping after the last one in use.
    function automatic logic [1:0] next_prog_idx(input logic [1:0]  idx,
                                                 input int unsigned num_progs);
        if (32'(idx) == num_progs - 1)
            return 2'd0;
        else
            return idx + 2'd1;
    endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Run-length counter for the program sequencer.
// Ports:
//   clk        clock, counts on posedge
//   rst_n      asynchronous active-low reset, clears the count
//   clear      synchronous clear (takes priority over enable)
//   enable     increment by one this cycle
//   count      current count
//   limit_hit  count is one below LIMIT, so the next increment reaches LIMIT
module seq_cycle_counter #(
    parameter int unsigned          CNT_W = 16,
    parameter logic [CNT_W-1:0]     LIMIT = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             limit_hit
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = LIMIT - CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable)
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count     = count_q;
    assign limit_hit = (count_q == LIMIT_M1);

endmodule

// File: rtl/program_sequencer.sv
// Run controller for the fetch unit. Each Start (launched on its falling
// edge) loads the next program's base address into the PC, enables fetch
// until Halt or the watchdog, then reports Done with the run's cycle count.
// Ports:
//   Clk         clock
//   Reset       asynchronous active-low reset
//   Start       launch request (level; launch on falling edge; aborts a run)
//   Halt        decoded halt instruction, only observed in RUN
//   PcLoad      one-cycle pulse telling the PC to take PcLoadAddr
//   PcLoadAddr  base address of program ProgIdx
//   FetchEn     PC may advance while high
//   Busy        high in ARMED, LOAD, RUN
//   Done        high while in DONE
//   Timeout     with Done: the run was stopped by the watchdog
//   ProgIdx     program to run next / currently running
//   CycleCount  RUN cycles of the current or last run
module program_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned      PC_W      = SEQ_PC_W,
    parameter int unsigned      NUM_PROGS = 3,
    parameter logic [PC_W-1:0]  BASE0     = PC_W'(0),
    parameter logic [PC_W-1:0]  BASE1     = PC_W'(256),
    parameter logic [PC_W-1:0]  BASE2     = PC_W'(512),
    parameter logic [PC_W-1:0]  BASE3     = PC_W'(768),
    parameter int unsigned      CNT_W     = 16,
    parameter logic [CNT_W-1:0] MAX_CYC   = CNT_W'(16'hFFF0)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    output logic             PcLoad,
    output logic [PC_W-1:0]  PcLoadAddr,
    output logic             FetchEn,
    output logic             Busy,
    output logic             Done,
    output logic             Timeout,
    output logic [1:0]       ProgIdx,
    output logic [CNT_W-1:0] CycleCount
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic [1:0] prog_idx_q;
    logic [1:0] prog_idx_d;
    logic       timeout_q;
    logic       timeout_d;
    logic       limit_hit;

    seq_cycle_counter #(
        .CNT_W (CNT_W),
        .LIMIT (MAX_CYC)
    ) u_cycle_counter (
        .clk       (Clk),
        .rst_n     (Reset),
        .clear     (state_q == LOAD),
        .enable    (state_q == RUN),
        .count     (CycleCount),
        .limit_hit (limit_hit)
    );

    // State and run-bookkeeping registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            prog_idx_q <= 2'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_idx_q <= prog_idx_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state. In RUN, Halt outranks the watchdog, which outranks abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = ARMED;
            ARMED:   if (!Start) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN: begin
                if (Halt)
                    state_d = DONE;
                else if (limit_hit)
                    state_d = DONE;
                else if (Start)
                    state_d = ARMED;
            end
            DONE:    if (Start) state_d = ARMED;
            default: state_d = IDLE;
        endcase
    end

    // Program index advances and the timeout flag is latched only on the
    // RUN -> DONE transition, so an aborted run reruns the same program.
    always_comb begin
        prog_idx_d = prog_idx_q;
        timeout_d  = timeout_q;
        if (state_q == LOAD)
            timeout_d = 1'b0;
        if (state_q == RUN && state_d == DONE) begin
            prog_idx_d = next_prog_idx(prog_idx_q, NUM_PROGS);
            timeout_d  = !Halt;
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        PcLoad  = (state_q == LOAD);
        FetchEn = (state_q == RUN);
        Busy    = (state_q == ARMED) || (state_q == LOAD) || (state_q == RUN);
        Done    = (state_q == DONE);
        Timeout = timeout_q && (state_q == DONE);
        ProgIdx = prog_idx_q;
    end

    // Base address mux, combinational from the program index.
    always_comb begin
        case (prog_idx_q)
            2'd0:    PcLoadAddr = BASE0;
            2'd1:    PcLoadAddr = BASE1;
            2'd2:    PcLoadAddr = BASE2;
            2'd3:    PcLoadAddr = BASE3;
            default: PcLoadAddr = BASE0;
        endcase
    end

endmodule
